// File: rtl/rps_match_scoreboard_if.sv
// ---------------------------------------------------------------------------
// rps_match_scoreboard_if
//
// Purpose: bundles the signals between the game-engine status stream, the
// match scoreboard and the display/LED logic that consumes the tallies.
//
// Signal summary:
//   status_in     engine -> scoreboard  8  {state[2:0], winner[1:0], debug[2:0]}
//   clear         engine -> scoreboard  1  synchronous match clear, active-high
//   p1_score      scoreboard -> display SCORE_W  player 1 round wins
//   p2_score      scoreboard -> display SCORE_W  player 2 round wins
//   tie_count     scoreboard -> display SCORE_W  tied rounds
//   invalid_count scoreboard -> display SCORE_W  rounds with winner code 2'b11
//   last_winner   scoreboard -> display 2  winner code of last counted round
//   round_strobe  scoreboard -> display 1  one-cycle pulse per counted round
//   match_done    scoreboard -> display 1  high while the match is over
//   match_winner  scoreboard -> display 2  01 = P1, 10 = P2, 00 = undecided
//   dbg_state     scoreboard -> display 1  FSM state (0 PLAYING, 1 MATCH_OVER)
//
// Handshake: there is no backpressure. round_strobe acts as a valid-only
// qualifier: it is high for exactly one cycle, during which the tallies and
// last_winner already show the result of that round; a consumer that wants
// to react per round must sample it in that cycle.
// ---------------------------------------------------------------------------
interface rps_match_scoreboard_if #(
    parameter int SCORE_W = 4
);
    logic [7:0]         status_in;
    logic               clear;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [SCORE_W-1:0] tie_count;
    logic [SCORE_W-1:0] invalid_count;
    logic [1:0]         last_winner;
    logic               round_strobe;
    logic               match_done;
    logic [1:0]         match_winner;
    logic               dbg_state;

    // Engine / test side: drives the status stream and clear.
    modport master (
        output status_in,
        output clear,
        input  p1_score,
        input  p2_score,
        input  tie_count,
        input  invalid_count,
        input  last_winner,
        input  round_strobe,
        input  match_done,
        input  match_winner,
        input  dbg_state
    );

    // Scoreboard side.
    modport slave (
        input  status_in,
        input  clear,
        output p1_score,
        output p2_score,
        output tie_count,
        output invalid_count,
        output last_winner,
        output round_strobe,
        output match_done,
        output match_winner,
        output dbg_state
    );
endinterface

// File: rtl/rps_match_scoreboard.sv
// ---------------------------------------------------------------------------
// rps_match_scoreboard
//
// Purpose: watches the stone-paper-scissors engine status byte, detects each
// completed round (entry into the RESULT state), tallies the round winner and
// declares the first player to reach WIN_TARGET round wins as match winner.
//
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   bus    rps_match_scoreboard_if.slave (status_in, clear in; tallies,
//          last_winner, round_strobe, match_done, match_winner, dbg_state out)
//
// Timing: status_in is registered (status_q) and the previous registered
// state code is kept (state_prev_q). A round event is combinational on those
// two registers, so a RESULT first sampled at edge N updates the tallies at
// edge N+1, and round_strobe is high during the cycle after edge N+1.
// ---------------------------------------------------------------------------
module rps_match_scoreboard #(
    parameter int WIN_TARGET = 3,
    parameter int SCORE_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    rps_match_scoreboard_if.slave     bus
);

    localparam logic [2:0]         ST_RESULT = 3'b010;
    localparam logic [SCORE_W-1:0] WIN_T     = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] ONE       = SCORE_W'(1);

    typedef enum logic {
        PLAYING    = 1'b0,
        MATCH_OVER = 1'b1
    } state_e;

    // Input stage
    logic [7:0]         status_q;
    logic [2:0]         state_prev_q;

    // Match state
    state_e             state_q,   state_d;
    logic [SCORE_W-1:0] p1_q,      p1_d;
    logic [SCORE_W-1:0] p2_q,      p2_d;
    logic [SCORE_W-1:0] tie_q,     tie_d;
    logic [SCORE_W-1:0] inv_q,     inv_d;
    logic [1:0]         last_q,    last_d;
    logic [1:0]         winner_q,  winner_d;
    logic               strobe_q,  strobe_d;

    logic               round_event;
    logic [1:0]         round_code;

    // The debug bits of the status byte carry no scoring information.
    logic               unused_debug_bits;
    assign unused_debug_bits = ^status_q[2:0];

    // -----------------------------------------------------------------------
    // Input stage: status register and previous state code. These keep
    // running in every FSM state and are not affected by clear, so a RESULT
    // held across a clear still yields only one event.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q     <= 8'h00;
            state_prev_q <= 3'b000;
        end else begin
            status_q     <= bus.status_in;
            state_prev_q <= status_q[7:5];
        end
    end

    // Rising edge into RESULT; holding RESULT produces a single event.
    assign round_event = (status_q[7:5] == ST_RESULT) && (state_prev_q != ST_RESULT);
    assign round_code  = status_q[4:3];

    // -----------------------------------------------------------------------
    // FSM and tally registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= PLAYING;
            p1_q     <= '0;
            p2_q     <= '0;
            tie_q    <= '0;
            inv_q    <= '0;
            last_q   <= 2'b00;
            winner_q <= 2'b00;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            tie_q    <= tie_d;
            inv_q    <= inv_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            strobe_q <= strobe_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / tally logic. Clear has priority over a coincident round
    // event: the round is dropped and no strobe is issued.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        tie_d    = tie_q;
        inv_d    = inv_q;
        last_d   = last_q;
        winner_d = winner_q;
        strobe_d = 1'b0;

        if (bus.clear) begin
            state_d  = PLAYING;
            p1_d     = '0;
            p2_d     = '0;
            tie_d    = '0;
            inv_d    = '0;
            last_d   = 2'b00;
            winner_d = 2'b00;
        end else begin
            case (state_q)
                PLAYING: begin
                    if (round_event) begin
                        last_d   = round_code;
                        strobe_d = 1'b1;
                        case (round_code)
                            2'b01: begin
                                // Scores never pass WIN_TARGET: reaching it
                                // ends the match and freezes the tallies.
                                p1_d = p1_q + ONE;
                                if (p1_d == WIN_T) begin
                                    state_d  = MATCH_OVER;
                                    winner_d = 2'b01;
                                end
                            end
                            2'b10: begin
                                p2_d = p2_q + ONE;
                                if (p2_d == WIN_T) begin
                                    state_d  = MATCH_OVER;
                                    winner_d = 2'b10;
                                end
                            end
                            2'b00: begin
                                if (tie_q != SCORE_MAX) begin
                                    tie_d = tie_q + ONE;
                                end
                            end
                            default: begin
                                if (inv_q != SCORE_MAX) begin
                                    inv_d = inv_q + ONE;
                                end
                            end
                        endcase
                    end
                end
                MATCH_OVER: begin
                    // Rounds are ignored until clear or reset.
                end
                default: begin
                    state_d = PLAYING;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.p1_score      = p1_q;
    assign bus.p2_score      = p2_q;
    assign bus.tie_count     = tie_q;
    assign bus.invalid_count = inv_q;
    assign bus.last_winner   = last_q;
    assign bus.round_strobe  = strobe_q;
    assign bus.match_done    = (state_q == MATCH_OVER);
    assign bus.match_winner  = winner_q;
    assign bus.dbg_state     = (state_q == MATCH_OVER);

endmodule

// File: tb/tb_rps_match_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_rps_match_scoreboard
//
// Drives the scoreboard with directed round sequences followed by random
// status streams. A round-level reference model tracks the match from the
// stream of status bytes handed to the design; each counted round pushes an
// expected snapshot into exp_q, and a monitor pops it whenever round_strobe
// is seen. The monitor also compares every output against the model once
// per cycle.
// ---------------------------------------------------------------------------
module tb_rps_match_scoreboard;

    localparam int SCORE_W    = 2;
    localparam int WIN_TARGET = 3;
    localparam int SAT_MAX    = (1 << SCORE_W) - 1;
    localparam int SNAP_W     = 4 * SCORE_W + 5;
    localparam int FULL_W     = SNAP_W + 2;

    logic clk;
    logic reset;

    rps_match_scoreboard_if #(.SCORE_W(SCORE_W)) bus ();

    rps_match_scoreboard #(
        .WIN_TARGET(WIN_TARGET),
        .SCORE_W   (SCORE_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [SNAP_W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Round-level view: what the match looks like after each clock edge.
    int         m_p1 = 0, m_p2 = 0, m_tie = 0, m_inv = 0;
    logic [1:0] m_last   = 2'b00;
    logic [1:0] m_winner = 2'b00;
    bit         m_over   = 1'b0;
    bit         m_strobe = 1'b0;
    // A status byte whose state entered RESULT, waiting for the next edge
    // to be scored (one edge to register it, one edge to score it).
    bit         pend      = 1'b0;
    logic [1:0] pend_code = 2'b00;
    logic [2:0] prev_st   = 3'b000;

    function automatic logic [SNAP_W-1:0] model_snap();
        return {SCORE_W'(m_p1), SCORE_W'(m_p2), SCORE_W'(m_tie), SCORE_W'(m_inv),
                m_last, m_over, m_winner};
    endfunction

    function automatic logic [SNAP_W-1:0] dut_snap();
        return {bus.p1_score, bus.p2_score, bus.tie_count, bus.invalid_count,
                bus.last_winner, bus.match_done, bus.match_winner};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic model_zero();
        m_p1 = 0; m_p2 = 0; m_tie = 0; m_inv = 0;
        m_last = 2'b00; m_winner = 2'b00; m_over = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drives one cycle of input and advances the
    // model to what the design must show after the next rising edge.
    task automatic step(input logic [7:0] st, input logic clr);
        logic [2:0] s;
        s = st[7:5];
        bus.status_in = st;
        bus.clear     = clr;
        m_strobe      = 1'b0;
        if (clr) begin
            model_zero();
        end else if (pend && !m_over) begin
            m_last   = pend_code;
            m_strobe = 1'b1;
            case (pend_code)
                2'b01: m_p1++;
                2'b10: m_p2++;
                2'b00: if (m_tie < SAT_MAX) m_tie++;
                default: if (m_inv < SAT_MAX) m_inv++;
            endcase
            if (m_p1 == WIN_TARGET) begin
                m_over = 1'b1; m_winner = 2'b01;
            end else if (m_p2 == WIN_TARGET) begin
                m_over = 1'b1; m_winner = 2'b10;
            end
            exp_q.push_back(model_snap());
        end
        pend      = (s == 3'b010) && (prev_st != 3'b010);
        pend_code = st[4:3];
        prev_st   = s;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting at a falling edge.
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        model_zero();
        m_strobe = 1'b0;
        pend     = 1'b0;
        prev_st  = 3'b000;
        #1;
        check("reset_async", {dut_snap(), bus.round_strobe, bus.dbg_state}, '0);
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] res(input logic [1:0] code);
        return {3'b010, code, 3'($urandom_range(0, 7))};
    endfunction

    task automatic play(input logic [1:0] code);
        logic [7:0] b;
        b = res(code);
        step(b, 1'b0);
        step(b, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #1;
        check("outputs", {dut_snap(), bus.round_strobe, bus.dbg_state},
              {model_snap(), m_strobe, m_over});
        if (bus.round_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("strobe_expected", 64'd0, 64'd1);
            end else begin
                check("round", dut_snap(), exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        logic [2:0] st;
        reset         = 1'b1;
        bus.status_in = 8'h00;
        bus.clear     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single round
        repeat (3) step(8'h00, 1'b0);
        repeat (5) step(8'b010_01_000, 1'b0);
        check("single_p1", bus.p1_score, 1);
        check("single_last", bus.last_winner, 2'b01);

        // Mixed rounds
        step(8'h00, 1'b1);
        play(2'b00); play(2'b11); play(2'b10); play(2'b10);
        check("mixed_tie", bus.tie_count, 1);
        check("mixed_inv", bus.invalid_count, 1);
        check("mixed_p2", bus.p2_score, 2);
        check("mixed_done", bus.match_done, 0);

        // Match completion, then an ignored round
        step(8'h00, 1'b1);
        play(2'b01); play(2'b01); play(2'b01);
        check("match_done", bus.match_done, 1);
        check("match_winner", bus.match_winner, 2'b01);
        play(2'b10);
        check("over_p2_frozen", bus.p2_score, 0);
        check("over_last_frozen", bus.last_winner, 2'b01);

        // Clear in the exact event cycle
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);
        b = res(2'b10);
        step(b, 1'b0);
        step(b, 1'b1);
        step(b, 1'b0);
        step(8'h00, 1'b0);
        check("collide_p2", bus.p2_score, 0);
        check("collide_state", bus.dbg_state, 0);
        play(2'b01);
        check("collide_follow_p1", bus.p1_score, 1);

        // Saturation of the tie counter
        step(8'h00, 1'b1);
        repeat (5) play(2'b00);
        check("tie_saturate", bus.tie_count, SAT_MAX);

        // Reset during a held RESULT
        step(8'h00, 1'b1);
        play(2'b01); play(2'b01);
        check("pre_reset_p1", bus.p1_score, 2);
        b = res(2'b01);
        step(b, 1'b0);
        do_reset(2);
        repeat (3) step(b, 1'b0);
        check("post_reset_p1", bus.p1_score, 1);
        step(8'h00, 1'b0);

        // Random streams
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                st = ($urandom_range(0, 2) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
                b  = {st, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
                step(b, ($urandom_range(0, 29) == 0));
            end
        end

        repeat (3) step(8'h00, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
